// File: rtl/teeter_pkg.sv
// ============================================================================
// Module      : teeter_pkg
// Description : Shared types and widths for the teeter motion controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package teeter_pkg;

    // Datapath widths
    localparam int POS_W     = 32;  // integer position from the integrator
    localparam int VEL_W     = 32;  // signed fixed-point velocity
    localparam int FRAC_BITS = 4;   // fractional bits in the velocity word
    localparam int TILT_W    = 4;   // signed tilt input
    localparam int START_W   = 10;  // start-position load value

    // Sequencer states; encoding is visible on o_state
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_CALC  = 3'd3,
        ST_CHECK = 3'd4
    } teeter_state_t;

endpackage

`default_nettype wire

// File: rtl/teeter_vel_sat.sv
// ============================================================================
// Module      : teeter_vel_sat
// Description : Combinational next-velocity generator. Either adds the scaled
//               tilt to the current velocity or negates it (bounce), then
//               saturates the result to +/-VEL_MAX.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module teeter_vel_sat
    import teeter_pkg::*;
#(
    parameter int ACCEL_SHIFT = 2,
    parameter int VEL_MAX     = 64
) (
    input  logic signed [VEL_W-1:0]  vel_in,
    input  logic signed [TILT_W-1:0] tilt,
    input  logic                     negate,
    output logic signed [VEL_W-1:0]  vel_out
);

    // Two guard bits cover the add overflow and negating the most negative value
    localparam int EXT_W = VEL_W + 2;
    localparam logic signed [EXT_W-1:0] C_POS_LIM = EXT_W'(VEL_MAX);
    localparam logic signed [EXT_W-1:0] C_NEG_LIM = -C_POS_LIM;

    logic signed [EXT_W-1:0] w_vel_ext;
    logic signed [EXT_W-1:0] w_accel;
    logic signed [EXT_W-1:0] w_raw;
    logic signed [EXT_W-1:0] w_sat;

    // Extend, add or negate, then clamp to the symmetric velocity limit
    always_comb begin
        w_vel_ext = {{2{vel_in[VEL_W-1]}}, vel_in};
        w_accel   = {{(EXT_W-TILT_W){tilt[TILT_W-1]}}, tilt};
        w_accel   = w_accel <<< ACCEL_SHIFT;
        if (negate) begin
            w_raw = -w_vel_ext;
        end else begin
            w_raw = w_vel_ext + w_accel;
        end
        if (w_raw > C_POS_LIM) begin
            w_sat = C_POS_LIM;
        end else if (w_raw < C_NEG_LIM) begin
            w_sat = C_NEG_LIM;
        end else begin
            w_sat = w_raw;
        end
    end

    assign vel_out = w_sat[VEL_W-1:0];

endmodule

`default_nettype wire

// File: rtl/teeter_motion_ctrl.sv
// ============================================================================
// Module      : teeter_motion_ctrl
// Description : Sequencer for the teeter ball-position integrator. Loads the
//               start position, issues a position-update strobe every
//               TICK_DIV cycles, integrates tilt into a saturating velocity
//               and raises the low/high clamp strobe when the returned
//               position reaches a board end.
//               Build option TEETER_BOUNCE_EN: a board-end hit reverses the
//               velocity and the run continues; without it a hit ends the run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module teeter_motion_ctrl
    import teeter_pkg::*;
#(
    parameter int TICK_DIV      = 500000,
    parameter int MIN_POS       = 0,
    parameter int MAX_POS       = 100,
    parameter int START_DEFAULT = 50,
    parameter int ACCEL_SHIFT   = 2,
    parameter int VEL_MAX       = 64
) (
    input  logic                     CLK,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_stop,
    input  logic [START_W-1:0]       i_start_pos,
    input  logic signed [TILT_W-1:0] i_tilt,
    input  logic [POS_W-1:0]         i_pos,
    output logic                     o_rst0,
    output logic [START_W-1:0]       o_rst0_value,
    output logic                     o_rst1,
    output logic                     o_rst2,
    output logic                     o_calc_time,
    output logic signed [VEL_W-1:0]  o_velocity,
    output logic [7:0]               o_bounces,
    output logic [2:0]               o_state
);

    // RUN lasts TICK_DIV-2 cycles: counter runs 0 .. TICK_DIV-3
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_DIV - 3);

    teeter_state_t             r_state;
    logic [CNT_W-1:0]          r_count;
    logic signed [VEL_W-1:0]   r_velocity;
    logic [7:0]                r_bounces;
    logic [START_W-1:0]        r_start_pos;
    logic                      r_rst0;
    logic                      r_calc;

    logic                      w_low_hit;
    logic                      w_high_hit;
    logic                      w_hit;
    logic signed [VEL_W-1:0]   w_vel_next;

    // Board-end detection against the position returned after the CALC strobe
    always_comb begin
        w_low_hit  = (r_state == ST_CHECK) && ($signed(i_pos) <= MIN_POS);
        w_high_hit = (r_state == ST_CHECK) && ($signed(i_pos) >= MAX_POS) && !w_low_hit;
        w_hit      = w_low_hit || w_high_hit;
    end

    // Next velocity: bounce negation on a hit, tilt integration otherwise
    teeter_vel_sat #(
        .ACCEL_SHIFT (ACCEL_SHIFT),
        .VEL_MAX     (VEL_MAX)
    ) u_vel_sat (
        .vel_in  (r_velocity),
        .tilt    (i_tilt),
        .negate  (w_hit),
        .vel_out (w_vel_next)
    );

    // Sequencer: state, tick counter, velocity, bounce count and strobes
    always_ff @(posedge CLK) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_velocity  <= '0;
            r_bounces   <= '0;
            r_start_pos <= START_W'(START_DEFAULT);
            r_rst0      <= 1'b0;
            r_calc      <= 1'b0;
        end else begin
            r_rst0 <= 1'b0;
            r_calc <= 1'b0;
            if ((r_state != ST_IDLE) && i_stop) begin
                // Abort wins over hit handling; strobes of this cycle stand
                r_state    <= ST_IDLE;
                r_velocity <= '0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        r_velocity <= '0;
                        if (i_start && !i_stop) begin
                            r_start_pos <= i_start_pos;
                            r_bounces   <= '0;
                            r_state     <= ST_LOAD;
                            r_rst0      <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        r_count <= '0;
                        r_state <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (r_count == C_LAST) begin
                            r_state <= ST_CALC;
                            r_calc  <= 1'b1;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                    ST_CALC: begin
                        r_state <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        r_count <= '0;
                        r_state <= ST_RUN;
                        if (w_hit) begin
                            if (r_bounces != 8'hFF) begin
                                r_bounces <= r_bounces + 8'd1;
                            end
`ifdef TEETER_BOUNCE_EN
                            r_velocity <= w_vel_next;
`else
                            r_velocity <= '0;
                            r_state    <= ST_IDLE;
`endif
                        end else begin
                            r_velocity <= w_vel_next;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_rst0       = r_rst0;
    assign o_calc_time  = r_calc;
    assign o_rst1       = w_low_hit;
    assign o_rst2       = w_high_hit;
    assign o_rst0_value = r_start_pos;
    assign o_velocity   = r_velocity;
    assign o_bounces    = r_bounces;
    assign o_state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_teeter_motion_ctrl.sv
// ============================================================================
// Module      : tb_teeter_motion_ctrl
// Description : Directed self-checking bench for teeter_motion_ctrl with
//               TICK_DIV=8 and a behavioural position integrator whose output
//               can be overridden to place the ball at chosen positions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_teeter_motion_ctrl;

    logic               clk;
    logic               rst;
    logic               start;
    logic               stop;
    logic [9:0]         start_pos;
    logic signed [3:0]  tilt;
    logic [31:0]        pos;
    logic               rst0;
    logic [9:0]         rst0_value;
    logic               rst1;
    logic               rst2;
    logic               calc_time;
    logic signed [31:0] velocity;
    logic [7:0]         bounces;
    logic [2:0]         state;

    logic signed [31:0] model_pos;
    logic               force_en;
    logic signed [31:0] force_val;

    int n_tests = 0;
    int n_fail  = 0;

    teeter_motion_ctrl #(
        .TICK_DIV      (8),
        .MIN_POS       (0),
        .MAX_POS       (100),
        .START_DEFAULT (50),
        .ACCEL_SHIFT   (2),
        .VEL_MAX       (64)
    ) dut (
        .CLK          (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_stop       (stop),
        .i_start_pos  (start_pos),
        .i_tilt       (tilt),
        .i_pos        (pos),
        .o_rst0       (rst0),
        .o_rst0_value (rst0_value),
        .o_rst1       (rst1),
        .o_rst2       (rst2),
        .o_calc_time  (calc_time),
        .o_velocity   (velocity),
        .o_bounces    (bounces),
        .o_state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural integrator: loads, clamps and adds the integer part of velocity
    always @(posedge clk) begin
        if (rst)            model_pos <= 32'sd50;
        else if (rst0)      model_pos <= $signed({22'd0, rst0_value});
        else if (rst1)      model_pos <= 32'sd0;
        else if (rst2)      model_pos <= 32'sd100;
        else if (calc_time) model_pos <= model_pos + (velocity >>> 4);
    end

    assign pos = force_en ? force_val : model_pos;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept a start in the current cycle; returns in cycle k=1 (LOAD)
    task automatic start_run(input logic [9:0] sp);
        start     = 1'b1;
        start_pos = sp;
        step();
        start = 1'b0;
    endtask

    task automatic stop_run();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_state", 32'(state), 32'd0);
        chk("stop_vel", velocity, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        start_pos = 10'd0;
        tilt      = 4'sd0;
        force_en  = 1'b0;
        force_val = 32'sd0;
        step_n(3);
        rst = 1'b0;

        // Reset / idle behaviour
        for (int k = 0; k < 20; k++) begin
            chk("idle_state", 32'(state), 32'd0);
            chk("idle_strobes", {28'd0, rst0, rst1, rst2, calc_time}, 32'd0);
            step();
        end
        chk("reset_rst0_value", 32'(rst0_value), 32'd50);
        chk("reset_vel", velocity, 32'd0);
        chk("reset_bounces", 32'(bounces), 32'd0);

        // Run 1: start at 30, tilt +3 -> velocity 12,24,...,60,64
        tilt = 4'sd3;
        start_run(10'd30);
        chk("run1_rst0_value", 32'(rst0_value), 32'd30);
        for (int k = 1; k <= 60; k++) begin
            int exp_v;
            int exp_s;
            exp_v = (k < 2) ? 0 : 12 * ((k - 2) / 8);
            if (exp_v > 64) exp_v = 64;
            if (k == 1)                exp_s = 1;
            else if (k % 8 == 0)       exp_s = 3;
            else if (k % 8 == 1)       exp_s = 4;
            else                       exp_s = 2;
            chk("run1_rst0", 32'(rst0), 32'(k == 1));
            chk("run1_calc", 32'(calc_time), 32'(k >= 8 && k % 8 == 0));
            chk("run1_clamps", {30'd0, rst1, rst2}, 32'd0);
            chk("run1_state", 32'(state), 32'(exp_s));
            chk("run1_vel", velocity, 32'(exp_v));
            step();
        end
        step_n(3);
        // k=64: CALC, place the ball on a board end for the following CHECK
        chk("hitA_calc", 32'(calc_time), 32'd1);
        force_en = 1'b1;
`ifdef TEETER_BOUNCE_EN
        force_val = 32'sd100;
`else
        force_val = -32'sd1;
`endif
        step();
        chk("hitA_state", 32'(state), 32'd4);
`ifdef TEETER_BOUNCE_EN
        chk("hitA_rst2", 32'(rst2), 32'd1);
        chk("hitA_rst1", 32'(rst1), 32'd0);
`else
        chk("hitA_rst1", 32'(rst1), 32'd1);
        chk("hitA_rst2", 32'(rst2), 32'd0);
`endif
        step();
        chk("hitA_bounces", 32'(bounces), 32'd1);
        chk("hitA_clamp_width", {30'd0, rst1, rst2}, 32'd0);
`ifdef TEETER_BOUNCE_EN
        chk("hitA_vel", velocity, -32'sd64);
        chk("hitA_next_state", 32'(state), 32'd2);
        stop_run();
        chk("hitA_stop_bounces", 32'(bounces), 32'd1);
`else
        chk("hitA_vel", velocity, 32'd0);
        chk("hitA_next_state", 32'(state), 32'd0);
`endif

        // Run 2: ball exactly at the low end (0) -> low clamp
        force_val = 32'sd0;
        start_run(10'h3FF);
        chk("run2_rst0_value", 32'(rst0_value), 32'h3FF);
        chk("run2_bounces_clear", 32'(bounces), 32'd0);
        step_n(8);
        chk("run2_rst1", 32'(rst1), 32'd1);
        chk("run2_rst2", 32'(rst2), 32'd0);
        step();
        chk("run2_bounces", 32'(bounces), 32'd1);
`ifdef TEETER_BOUNCE_EN
        chk("run2_state", 32'(state), 32'd2);
        stop_run();
`else
        chk("run2_state", 32'(state), 32'd0);
`endif

        // Run 3: 99 is not a hit; tilt -8 integrates to -32; stop in CALC
        force_val = 32'sd99;
        tilt      = -4'sd8;
        start_run(10'd5);
        step_n(8);
        chk("run3_no_hit", {30'd0, rst1, rst2}, 32'd0);
        step();
        chk("run3_vel", velocity, -32'sd32);
        chk("run3_bounces", 32'(bounces), 32'd0);
        step_n(6);
        chk("run3_calc", 32'(calc_time), 32'd1);
        stop  = 1'b1;
        start = 1'b1;
        step();
        stop  = 1'b0;
        start = 1'b0;
        chk("stop_calc_state", 32'(state), 32'd0);
        chk("stop_calc_vel", velocity, 32'd0);
        chk("stop_calc_rst0", 32'(rst0), 32'd0);
        step();
        chk("stop_calc_idle", 32'(state), 32'd0);
        chk("stop_calc_strobes", {28'd0, rst0, rst1, rst2, calc_time}, 32'd0);

        // Run 4: ball exactly at the high end (100) -> high clamp
        force_val = 32'sd100;
        tilt      = 4'sd0;
        start_run(10'd7);
        step_n(8);
        chk("run4_rst2", 32'(rst2), 32'd1);
        chk("run4_rst1", 32'(rst1), 32'd0);
        step();
        chk("run4_bounces", 32'(bounces), 32'd1);
`ifdef TEETER_BOUNCE_EN
        chk("run4_state", 32'(state), 32'd2);
        stop_run();
`else
        chk("run4_state", 32'(state), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
